// File: rtl/tbl_rd_port_ctrl.sv
// Read-side controller for a dual-port table RAM: credit-gated request path, 1-cycle RAM capture,
// response FIFO. Optional write-to-read forwarding is enabled by defining TBL_RD_WR_FWD_EN.
module tbl_rd_port_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_aresetn,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic                  o_ram_en,
    input  logic [DATA_WIDTH-1:0] i_ram_dout,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_data,
    output logic [ADDR_WIDTH-1:0] o_rsp_addr
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] r_mem_addr [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_inflight_v;
    logic [ADDR_WIDTH-1:0] r_inflight_addr;

    logic                  w_pop;
    logic                  w_accept;
    logic [CNT_W:0]        w_pending;
    logic [DATA_WIDTH-1:0] w_push_data;

    assign o_rsp_valid = (r_count != '0);
    assign o_rsp_data  = r_mem_data[r_rptr];
    assign o_rsp_addr  = r_mem_addr[r_rptr];
    assign w_pop       = o_rsp_valid & i_rsp_ready;

    // Credits: buffered + in-flight entries, minus the slot freed by a pop this cycle.
    assign w_pending   = {1'b0, r_count} + (CNT_W + 1)'(r_inflight_v) - (CNT_W + 1)'(w_pop);
    assign o_req_ready = i_aresetn & (w_pending < DEPTH_C);
    assign w_accept    = i_req_valid & o_req_ready;
    assign o_ram_addr  = i_req_addr;
    assign o_ram_en    = w_accept;

`ifdef TBL_RD_WR_FWD_EN
    logic                  r_fwd_v;
    logic [DATA_WIDTH-1:0] r_fwd_data;

    // The RAM returns old data on a same-edge collision, so remember the written word.
    always_ff @(posedge i_clk) begin
        if (!i_aresetn) begin
            r_fwd_v    <= 1'b0;
            r_fwd_data <= '0;
        end else begin
            r_fwd_v    <= w_accept & i_wr_en & (i_wr_addr == i_req_addr);
            r_fwd_data <= i_wr_data;
        end
    end

    assign w_push_data = r_fwd_v ? r_fwd_data : i_ram_dout;
`else
    logic w_unused_wr;
    assign w_unused_wr = ^{i_wr_en, i_wr_addr, i_wr_data};
    assign w_push_data = i_ram_dout;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_aresetn) begin
            r_wptr          <= '0;
            r_rptr          <= '0;
            r_count         <= '0;
            r_inflight_v    <= 1'b0;
            r_inflight_addr <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_mem_data[i] <= '0;
                r_mem_addr[i] <= '0;
            end
        end else begin
            r_inflight_v    <= w_accept;
            r_inflight_addr <= i_req_addr;
            if (r_inflight_v) begin
                r_mem_data[r_wptr] <= w_push_data;
                r_mem_addr[r_wptr] <= r_inflight_addr;
                r_wptr             <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(r_inflight_v) - CNT_W'(w_pop);
        end
    end

endmodule

// File: tb/tb_tbl_rd_port_ctrl.sv
// Bench for tbl_rd_port_ctrl: behavioural RAM plus a queue-based reference of outstanding lookups.
module tb_tbl_rd_port_ctrl;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          aresetn;
    logic          req_valid, req_ready;
    logic [AW-1:0] req_addr, ram_addr;
    logic          ram_en;
    logic [DW-1:0] ram_dout;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] rsp_addr;

    tbl_rd_port_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk      (clk),
        .i_aresetn  (aresetn),
        .i_req_valid(req_valid),
        .o_req_ready(req_ready),
        .i_req_addr (req_addr),
        .o_ram_addr (ram_addr),
        .o_ram_en   (ram_en),
        .i_ram_dout (ram_dout),
        .i_wr_en    (wr_en),
        .i_wr_addr  (wr_addr),
        .i_wr_data  (wr_data),
        .o_rsp_valid(rsp_valid),
        .i_rsp_ready(rsp_ready),
        .o_rsp_data (rsp_data),
        .o_rsp_addr (rsp_addr)
    );

    always #5 clk = ~clk;

    // Simple dual-port RAM: read-first on a same-address collision, read port always enabled.
    logic [DW-1:0] ram [16];
    always @(posedge clk) begin
        if (wr_en) ram[wr_addr] <= wr_data;
        ram_dout <= ram[ram_addr];
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            due;
    } ent_t;

    ent_t          q[$];
    logic [DW-1:0] ref_mem [16];
    int            edge_n = 0;
    int            checks = 0;
    int            failures = 0;
    int            acc_cnt;
    logic          last_acc, last_dut_ready, last_dut_valid;
    logic [DW-1:0] last_dut_data, last_pop_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, compare against the model, advance the model past the edge.
    task automatic cyc(input logic v, input logic [AW-1:0] a, input logic rr,
                       input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        logic          exp_valid, exp_ready, exp_pop;
        logic [DW-1:0] d;
        int            pending;
        req_valid = v; req_addr = a; rsp_ready = rr;
        wr_en = we; wr_addr = wa; wr_data = wd;
        #1;
        exp_valid = (q.size() > 0) && (edge_n >= q[0].due);
        exp_pop   = exp_valid && rr;
        pending   = q.size() - (exp_pop ? 1 : 0);
        exp_ready = (pending < DEPTH);
        chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_valid});
        if (exp_valid) begin
            chk("rsp_data", {24'd0, rsp_data}, {24'd0, q[0].data});
            chk("rsp_addr", {28'd0, rsp_addr}, {28'd0, q[0].addr});
        end
        chk("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
        chk("ram_en", {31'd0, ram_en}, {31'd0, v & exp_ready});
        chk("ram_addr", {28'd0, ram_addr}, {28'd0, a});
        last_dut_ready = req_ready;
        last_dut_valid = rsp_valid;
        last_dut_data  = rsp_data;
        if (exp_pop) begin
            last_pop_data = rsp_data;
            void'(q.pop_front());
        end
        last_acc = v & exp_ready;
        if (last_acc) begin
            d = ref_mem[a];
`ifdef TBL_RD_WR_FWD_EN
            if (we && wa == a) d = wd;
`endif
            q.push_back('{addr: a, data: d, due: edge_n + 2});
            acc_cnt++;
        end
        if (we) ref_mem[wa] = wd;
        @(posedge clk);
        edge_n++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        req_valid = 1'b1; req_addr = 4'd9; rsp_ready = 1'b1; wr_en = 1'b0;
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
        @(posedge clk);
        edge_n++;
        q.delete();
        @(negedge clk);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
        chk("rst_rsp_addr", {28'd0, rsp_addr}, 32'd0);
        aresetn = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() > 0; i++) cyc(1'b0, '0, 1'b1, 1'b0, '0, '0);
        chk("drain_done", q.size(), 32'd0);
    endtask

    initial begin
        logic [AW-1:0] a;
        aresetn = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        acc_cnt = 0;
        @(negedge clk);
        do_reset();

        // Preload RAM[i] = i + 0x10, then RAM[3] = 0xA5.
        for (int i = 0; i < 16; i++) cyc(1'b0, '0, 1'b1, 1'b1, 4'(i), 8'(i + 16));
        cyc(1'b0, '0, 1'b1, 1'b1, 4'd3, 8'hA5);

        // Single read with explicit 2-cycle latency.
        cyc(1'b1, 4'd3, 1'b0, 1'b0, '0, '0);
        cyc(1'b0, '0, 1'b0, 1'b0, '0, '0);
        chk("lat_edge1_valid", {31'd0, last_dut_valid}, 32'd0);
        cyc(1'b0, '0, 1'b1, 1'b0, '0, '0);
        chk("lat_edge2_valid", {31'd0, last_dut_valid}, 32'd1);
        chk("single_read_data", {24'd0, last_dut_data}, 32'hA5);
        cyc(1'b0, '0, 1'b1, 1'b1, 4'd3, 8'h13);

        // Streaming 0..15 with rsp_ready held high.
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 4'(i), 1'b1, 1'b0, '0, '0);
            chk("stream_ready", {31'd0, last_dut_ready}, 32'd1);
        end
        drain();

        // Backpressure: only DEPTH requests fit.
        acc_cnt = 0;
        a = 4'd1;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, a, 1'b0, 1'b0, '0, '0);
            if (last_acc) a++;
        end
        chk("bp_accepted", acc_cnt, 32'd4);
        chk("bp_ready_low", {31'd0, last_dut_ready}, 32'd0);
        for (int i = 0; i < 10 && a == 4'd5; i++) begin
            cyc(1'b1, a, 1'b1, 1'b0, '0, '0);
            if (last_acc) a++;
        end
        chk("bp_addr5_accepted", {28'd0, a}, 32'd6);
        drain();

        // Reset with 3 buffered and 1 in flight.
        for (int i = 0; i < 4; i++) cyc(1'b1, 4'(i + 8), 1'b0, 1'b0, '0, '0);
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b0, '0, '0);
        chk("post_rst_ready", {31'd0, last_dut_ready}, 32'd1);

        // Read/write collision on addr 7.
        cyc(1'b0, '0, 1'b1, 1'b1, 4'd7, 8'h11);
        cyc(1'b1, 4'd7, 1'b1, 1'b1, 4'd7, 8'h22);
        drain();
`ifdef TBL_RD_WR_FWD_EN
        chk("collision_data", {24'd0, last_pop_data}, 32'h22);
`else
        chk("collision_data", {24'd0, last_pop_data}, 32'h11);
`endif
        cyc(1'b1, 4'd7, 1'b1, 1'b0, '0, '0);
        drain();
        chk("reread_data", {24'd0, last_pop_data}, 32'h22);

        // Full FIFO, single-cycle rsp_ready pulse admits exactly one request.
        for (int i = 0; i < 6; i++) cyc(1'b1, 4'(i), 1'b0, 1'b0, '0, '0);
        acc_cnt = 0;
        cyc(1'b1, 4'd12, 1'b1, 1'b0, '0, '0);
        chk("full_pulse_ready", {31'd0, last_dut_ready}, 32'd1);
        cyc(1'b1, 4'd13, 1'b0, 1'b0, '0, '0);
        chk("full_after_ready", {31'd0, last_dut_ready}, 32'd0);
        chk("full_pulse_accepts", acc_cnt, 32'd1);
        drain();

        // Randomized traffic including writes that sometimes collide with the lookup.
        for (int i = 0; i < 600; i++) begin
            logic [AW-1:0] ra, wa;
            ra = 4'($urandom_range(0, 15));
            wa = ($urandom_range(0, 3) == 0) ? ra : 4'($urandom_range(0, 15));
            cyc(1'($urandom_range(0, 1)), ra, ($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)), wa, 8'($urandom));
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end
endmodule
